refill_arbiter: RTL and testbench

//  Shares the single burst_controller refill channel (instr memory port 1) between two cache requesters:

---
 rtl/refill_arbiter.sv | 125 ++++++++++++
 tb/tb_refill_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/refill_arbiter.sv
// Two-port round-robin arbiter for the burst refill channel; grant held for a whole burst.
// Beat forwarding is zero-latency; ack is registered; a burst stalled past TIMEOUT_CYCLES is aborted.
module refill_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BLOCK_SIZE     = 8,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int LEN_W         = $clog2(BLOCK_SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s0_req,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic [LEN_W-1:0]      s0_burst_len,
  output logic                  s0_ack,
  output logic [DATA_WIDTH-1:0] s0_data,
  output logic                  s0_valid,
  output logic                  s0_last,
  input  logic                  s1_req,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic [LEN_W-1:0]      s1_burst_len,
  output logic                  s1_ack,
  output logic [DATA_WIDTH-1:0] s1_data,
  output logic                  s1_valid,
  output logic                  s1_last,
  output logic                  m_req,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [LEN_W-1:0]      m_burst_len,
  input  logic                  m_ready,
  input  logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_valid,
  input  logic                  m_last,
  output logic                  busy,
  output logic                  grant_id,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state, state_nxt;
  logic            last_grant;
  logic            ack_pulse;
  logic [WD_W-1:0] wd;
  logic            any_req;
  logic            sel;
  logic            timeout_hit;
  logic            burst_done;

  assign any_req = s0_req | s1_req;
  // On contention, the port that did not win last time gets the channel.
  assign sel     = (s0_req & s1_req) ? ~last_grant : s1_req;

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    burst_done  = 1'b0;
    case (state)
      IDLE:  if (any_req) state_nxt = ISSUE;
      ISSUE: if (m_ready) state_nxt = BURST;
      BURST: begin
        if (m_valid && m_last) begin
          burst_done = 1'b1;
          state_nxt  = IDLE;
        end else if (!m_valid && wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant_id    <= 1'b0;
      m_addr      <= '0;
      m_burst_len <= '0;
      wd          <= '0;
      ack_pulse   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      ack_pulse <= (state == IDLE) && any_req;
      if (state == IDLE && any_req) begin
        grant_id    <= sel;
        m_addr      <= sel ? s1_addr : s0_addr;
        m_burst_len <= sel ? s1_burst_len : s0_burst_len;
      end
      if (state != BURST || m_valid) wd <= '0;
      else                           wd <= wd + 1'b1;
      if (burst_done || timeout_hit) last_grant <= grant_id;
      if (timeout_hit)               timeout_err <= 1'b1;
    end
  end

  always_comb begin
    s0_ack   = ack_pulse & ~grant_id;
    s1_ack   = ack_pulse & grant_id;
    m_req    = (state == ISSUE);
    busy     = (state != IDLE);
    s0_valid = 1'b0;
    s0_last  = 1'b0;
    s0_data  = '0;
    s1_valid = 1'b0;
    s1_last  = 1'b0;
    s1_data  = '0;
    // Beats outside BURST are dropped; only the granted port sees traffic.
    if (state == BURST) begin
      if (grant_id) begin
        s1_valid = m_valid;
        s1_last  = m_last;
        s1_data  = m_data;
      end else begin
        s0_valid = m_valid;
        s0_last  = m_last;
        s0_data  = m_data;
      end
    end
  end

endmodule

// File: tb/tb_refill_arbiter.sv
// Directed bench for refill_arbiter: arbitration order, beat routing, ISSUE stall, watchdog abort, reset mid-burst.
module tb_refill_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          s0_req, s1_req;
  logic [AW-1:0] s0_addr, s1_addr;
  logic [LW-1:0] s0_burst_len, s1_burst_len;
  logic          s0_ack, s1_ack;
  logic [DW-1:0] s0_data, s1_data;
  logic          s0_valid, s1_valid, s0_last, s1_last;
  logic          m_req;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_burst_len;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last;
  logic          busy, grant_id, timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  refill_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(8), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .s0_req(s0_req), .s0_addr(s0_addr), .s0_burst_len(s0_burst_len), .s0_ack(s0_ack),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last),
    .s1_req(s1_req), .s1_addr(s1_addr), .s1_burst_len(s1_burst_len), .s1_ack(s1_ack),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last),
    .m_req(m_req), .m_addr(m_addr), .m_burst_len(m_burst_len), .m_ready(m_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives n beats of a burst of `tot` beats on the channel, checking routing to `port`.
  task automatic beats(input int port, input int n, input int tot, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      m_valid = 1'b1;
      m_data  = base + DW'(i);
      m_last  = (i == tot - 1);
      #1;
      total++;
      if ((port == 0 ? {s0_valid, s0_last, s0_data} : {s1_valid, s1_last, s1_data}) !== {1'b1, (i == tot - 1), base + DW'(i)}) begin
        bad++;
        $display("FAIL beat%0d_p%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h", i, port,
                 port == 0 ? s0_valid : s1_valid, port == 0 ? s0_last : s1_last,
                 port == 0 ? s0_data : s1_data, (i == tot - 1), base + DW'(i));
      end
      total++;
      if ((port == 0 ? {s1_valid, s1_last, s1_data} : {s0_valid, s0_last, s0_data}) !== '0) begin
        bad++;
        $display("FAIL beat%0d_other_port: non-granted port saw traffic, want all 0", i);
      end
      tick();
    end
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_data  = '0;
    #1;
    if (n == tot) begin
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_burst: busy=%b want 0", busy); end
    end
  endtask

  // Entered in the first ISSUE cycle with m_ready=1: checks ack/grant/address then runs the burst.
  task automatic serve(input int port, input logic [AW-1:0] addr, input int nb, input logic [DW-1:0] base);
    total++;
    if ({s0_ack, s1_ack} !== (port == 0 ? 2'b10 : 2'b01)) begin
      bad++; $display("FAIL ack_p%0d: got s0_ack=%b s1_ack=%b", port, s0_ack, s1_ack);
    end
    total++;
    if (grant_id !== port[0]) begin bad++; $display("FAIL grant_id: got %b want %0d", grant_id, port); end
    total++;
    if ({m_req, m_addr, m_burst_len} !== {1'b1, addr, LW'(nb - 1)}) begin
      bad++; $display("FAIL issue_p%0d: m_req=%b addr=%h len=%0d want 1 %h %0d", port, m_req, m_addr, m_burst_len, addr, nb - 1);
    end
    if (port == 0) s0_req = 1'b0; else s1_req = 1'b0;
    tick();
    total++;
    if ({m_req, s0_ack, s1_ack, busy} !== 4'b0001) begin
      bad++; $display("FAIL burst_entry: m_req=%b acks=%b%b busy=%b want 0 00 1", m_req, s0_ack, s1_ack, busy);
    end
    beats(port, nb, nb, base);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({busy, m_req, s0_ack, s1_ack, s0_valid, s1_valid, timeout_err, grant_id} !== 8'h00) begin
      bad++; $display("FAIL reset_flags: busy=%b m_req=%b timeout_err=%b grant_id=%b want all 0", busy, m_req, timeout_err, grant_id);
    end
    total++;
    if ({m_addr, m_burst_len, s0_data, s1_data} !== '0) begin
      bad++; $display("FAIL reset_data: m_addr=%h m_burst_len=%0d want 0", m_addr, m_burst_len);
    end
  endtask

  task automatic test_single();
    s0_addr = 32'h100; s0_burst_len = 4'd7; s0_req = 1'b1;
    tick();
    serve(0, 32'h100, 8, 32'hA000);
  endtask

  task automatic test_both();
    do_reset();
    s0_addr = 32'h200; s0_burst_len = 4'd1;
    s1_addr = 32'h280; s1_burst_len = 4'd2;
    s0_req = 1'b1; s1_req = 1'b1;
    tick();
    serve(0, 32'h200, 2, 32'hB000);
    tick();
    serve(1, 32'h280, 3, 32'hB100);
  endtask

  task automatic test_back_to_back();
    s0_addr = 32'h600; s0_burst_len = 4'd0;
    s1_addr = 32'h680; s1_burst_len = 4'd1;
    s0_req = 1'b1; s1_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k % 2 == 0) serve(0, 32'h600, 1, 32'hC000 + DW'(k << 4));
      else            serve(1, 32'h680, 2, 32'hC000 + DW'(k << 4));
      s0_req = 1'b1; s1_req = 1'b1;
    end
    s0_req = 1'b0; s1_req = 1'b0;
  endtask

  task automatic test_issue_stall();
    m_ready = 1'b0;
    s1_addr = 32'h300; s1_burst_len = 4'd3; s1_req = 1'b1;
    tick();
    total++;
    if (s1_ack !== 1'b1) begin bad++; $display("FAIL stall_ack: s1_ack=%b want 1", s1_ack); end
    s1_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({m_req, m_addr, timeout_err} !== {1'b1, 32'h300, 1'b0}) begin
        bad++; $display("FAIL stall_hold%0d: m_req=%b addr=%h terr=%b want 1 300 0", i, m_req, m_addr, timeout_err);
      end
      if (i == 4) m_ready = 1'b1;
      tick();
    end
    total++;
    if ({m_req, s1_ack} !== 2'b00) begin bad++; $display("FAIL stall_release: m_req=%b s1_ack=%b want 0 0", m_req, s1_ack); end
    beats(1, 4, 4, 32'hD000);
  endtask

  task automatic test_timeout();
    s0_addr = 32'h400; s0_burst_len = 4'd7; s0_req = 1'b1;
    tick();
    s0_req = 1'b0;
    tick();
    beats(0, 3, 8, 32'hE000);
    for (int i = 0; i < 60; i++) tick();
    total++;
    if ({busy, timeout_err} !== 2'b10) begin bad++; $display("FAIL wd_early: busy=%b terr=%b want 1 0", busy, timeout_err); end
    for (int i = 0; i < 10; i++) tick();
    total++;
    if ({busy, timeout_err} !== 2'b01) begin bad++; $display("FAIL wd_abort: busy=%b terr=%b want 0 1", busy, timeout_err); end
    m_valid = 1'b1; m_data = 32'hDEAD; #1;
    total++;
    if ({s0_valid, s1_valid, s0_data, s1_data} !== '0) begin bad++; $display("FAIL idle_beat_leak: s0_valid=%b s1_valid=%b want 0", s0_valid, s1_valid); end
    m_valid = 1'b0; m_data = '0;
    s1_addr = 32'h480; s1_burst_len = 4'd1; s1_req = 1'b1;
    tick();
    serve(1, 32'h480, 2, 32'hE100);
    total++;
    if (timeout_err !== 1'b1) begin bad++; $display("FAIL terr_sticky: timeout_err=%b want 1", timeout_err); end
  endtask

  task automatic test_rst_mid();
    s1_addr = 32'h500; s1_burst_len = 4'd7; s1_req = 1'b1;
    tick();
    s1_req = 1'b0;
    tick();
    beats(1, 3, 8, 32'hF000);
    m_valid = 1'b1; m_data = 32'hF003; rst = 1'b1;
    tick();
    rst = 1'b0; m_valid = 1'b0; m_data = '0;
    #1;
    total++;
    if ({busy, m_req, s1_ack, s1_valid, s1_last, timeout_err, grant_id} !== 7'h00) begin
      bad++; $display("FAIL rst_mid: busy=%b m_req=%b s1_valid=%b terr=%b grant=%b want all 0", busy, m_req, s1_valid, timeout_err, grant_id);
    end
    total++;
    if ({m_addr, s1_data} !== '0) begin bad++; $display("FAIL rst_mid_data: m_addr=%h s1_data=%h want 0", m_addr, s1_data); end
    s1_req = 1'b1;
    tick();
    serve(1, 32'h500, 8, 32'hF100);
  endtask

  initial begin
    rst = 1'b1;
    s0_req = 1'b0; s1_req = 1'b0;
    s0_addr = '0; s1_addr = '0; s0_burst_len = '0; s1_burst_len = '0;
    m_ready = 1'b1; m_data = '0; m_valid = 1'b0; m_last = 1'b0;
    test_reset();
    test_single();
    test_both();
    test_back_to_back();
    test_issue_stall();
    test_timeout();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
